mux_n_arb: RTL and testbench
============================

# mux_n_arb

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on every input and on the output. It is the datapath-steering successor to the two-input mux used in the carry-skip adder. It provides two modes:
- externally selected channel;
- fair round-robin arbitration across channels.

It has one output register stage and sits between operand sources and the adder pipeline.

## Interface
Parameters:
- WIDTH, 16, data width per channel (>=1)
- CHANNELS, 4, number of input channels (>=2)
- MODE, 0, 0 = select mode (sel input chooses channel), 1 = round-robin arbitration
- SEL_W, derived = clog2(CHANNELS), width of sel/out_chan; not user-set

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  CHANNELS*WIDTH  flattened channel data, channel k at bits [k*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready (combinational)
- sel  input  SEL_W  channel select, used only when MODE=0
- out_data  output  WIDTH  registered output data
- out_valid  output  1  registered output valid
- out_ready  input  1  downstream ready
- out_chan  output  SEL_W  index of channel that supplied the current output beat

## Operation
- Output register accepts a new beat when load_en = !out_valid || out_ready.
- Transfer on channel k: in_valid[k] && in_ready[k] at a rising clk edge. Output transfer: out_valid && out_ready.
- At most one in_ready bit is high in any cycle. in_ready is all-zero while rst is high.

MODE=0 (select):
- in_ready[sel] = load_en. All other in_ready bits are 0.
- sel >= CHANNELS (non-power-of-two CHANNELS) grants nothing: all in_ready are 0 and no beat is loaded.

MODE=1 (round-robin):
- A pointer ptr holds the last granted channel.
- Grant goes to the first k with in_valid[k] set, searching ptr+1, ptr+2, … and wrapping modulo CHANNELS.
- in_ready[grant] = load_en && |in_valid.
- On a transfer from channel k, ptr <= k. The pointer is unchanged when there is no transfer.

On a load with transfer from channel k: out_data <= channel k data, out_chan <= k, out_valid <= 1.

On load_en with no transfer: out_valid <= 0. out_data and out_chan hold their previous values.

Reset values:
- out_valid = 0, out_data = 0, out_chan = 0
- ptr = CHANNELS-1, so channel 0 has first priority after reset.

## Timing
- Latency is 1 cycle, input transfer to out_valid.
- Throughput is 1 beat/cycle with out_ready held high.
- Backpressure (out_valid && !out_ready):
  - out_data and out_chan are held stable and all in_ready are 0.
  - Changes on sel or in_valid during the stall do not affect the held beat.
- Simultaneous out_ready and new input: the old beat leaves and the new beat loads on the same edge, so out_valid stays 1.
- An input may drop in_valid while not granted; no state changes.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronously) and any held beat is discarded. The first grant after deassert follows reset priority.
- No combinational path from out_ready to out_data. in_ready depends combinationally on out_ready, out_valid, sel (MODE=0) and in_valid (MODE=1).

## Structure
- Shared package mux_pkg holds:
  - MODE_SEL = 0 and MODE_RR = 1 constants;
  - the clog2 function used to derive SEL_W.
- Sub-module rr_arbiter (CHANNELS parameter):
  - owns ptr and the wrapped priority search;
  - inputs clk, rst, req[CHANNELS], advance;
  - outputs one-hot gnt and gnt_idx;
  - instantiated only when MODE=1.
- The top level holds the output register and the handshake logic.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4.
- MODE=0, sel=2, in_data ch2=0xA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=0xA5, out_chan=2.
- MODE=0, out_ready=0 with out_valid=1 holding 0x11; change sel and data for 3 cycles -> out_data stays 0x11 and in_ready=0. Raise out_ready -> 0x11 is consumed and the new beat loads on the same edge.
- MODE=1, all four channels valid continuously (data 0x10,0x20,0x30,0x40), out_ready=1 -> out_chan sequence 0,1,2,3,0,… and out_data 0x10,0x20,0x30,0x40,0x10.
- MODE=1, ptr=1 after grant to ch1, only ch0 and ch3 valid -> grant ch3 then ch0 (wrap-around); no grant to an invalid channel.
- Reset asserted while out_valid=1 and out_ready=0 -> out_valid=0, out_data=0, out_chan=0 immediately. After release with all channels valid (MODE=1) -> first grant is ch0.
- MODE=1, in_valid=0 for 2 cycles after a beat is consumed -> out_valid=0, ptr unchanged; next single request on ch2 -> out_chan=2 one cycle later.

Source files
------------

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the N-channel registered mux and its round-robin
// arbiter.
//   MODE_SEL / MODE_RR : values for the mux MODE parameter
//   clog2()            : index width needed to address a number of channels
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Number of bits needed to hold an index in [0, value-1]. The result is
    // never below 1, so even a two-channel mux has a real select bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_n_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Fair round-robin arbiter. It remembers the last granted channel and
// searches for the next requester starting just after it, wrapping around.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : per-channel request (the channel's valid)
//   advance   : high when the current grant is actually transferred
//   gnt       : one-hot grant, all-zero when nothing requests
//   gnt_idx   : binary index of the granted channel
// -----------------------------------------------------------------------------
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int IDX_W    = clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [CHANNELS-1:0] gnt,
    output logic [IDX_W-1:0]    gnt_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;
    int               candidate;

    // Wrapped priority search: walk ptr+1, ptr+2, ... modulo CHANNELS and
    // stop at the first requester. The inner loop turns the computed
    // candidate into a constant bit select so no out-of-range index is built.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        candidate = 0;
        for (int offset = 1; offset <= CHANNELS; offset++) begin
            candidate = int'(ptr_q) + offset;
            if (candidate >= CHANNELS) begin
                candidate = candidate - CHANNELS;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (!found && (k == candidate) && req[k]) begin
                    found    = 1'b1;
                    gnt[k]   = 1'b1;
                    gnt_idx  = IDX_W'(k);
                end
            end
        end
    end

    // The pointer only moves when a grant is really consumed, so a stalled
    // or idle output never costs a channel its turn.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = gnt_idx;
        end
    end

    // Starting at the last channel gives channel 0 first priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IDX_W'(CHANNELS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mux_n_arb.sv
// -----------------------------------------------------------------------------
// mux_n_arb
// N-channel, WIDTH-bit registered multiplexer with valid/ready on every input
// and on the output. MODE_SEL steers the channel chosen by sel; MODE_RR picks
// channels fairly with a round-robin arbiter.
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready, at most one bit high, combinational
//   sel        : channel select (MODE_SEL only)
//   out_data   : registered output data
//   out_valid  : registered output valid
//   out_ready  : downstream ready
//   out_chan   : channel that supplied the current output beat
// -----------------------------------------------------------------------------
module mux_n_arb
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = MODE_SEL,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    logic                loadEn;
    logic [CHANNELS-1:0] selOneHot;
    logic [CHANNELS-1:0] arbGnt;
    logic [SEL_W-1:0]    arbIdx;
    logic [CHANNELS-1:0] grantVec;
    logic [SEL_W-1:0]    grantIdx;
    logic                transfer;
    logic [WIDTH-1:0]    chData;

    logic                outValid_q;
    logic                outValid_d;
    logic [WIDTH-1:0]    outData_q;
    logic [WIDTH-1:0]    outData_d;
    logic [SEL_W-1:0]    outChan_q;
    logic [SEL_W-1:0]    outChan_d;

    // The output register can take a beat when it is empty or being drained.
    assign loadEn = !outValid_q || out_ready;

    // A select value beyond the last channel shifts the bit out entirely,
    // which is exactly the "grant nothing" behaviour wanted there.
    assign selOneHot = {{(CHANNELS-1){1'b0}}, 1'b1} << sel;

    generate
        if (MODE == MODE_RR) begin : gen_rr
            rr_arbiter #(
                .CHANNELS (CHANNELS)
            ) u_rr_arbiter (
                .clk     (clk),
                .rst     (rst),
                .req     (in_valid),
                .advance (transfer),
                .gnt     (arbGnt),
                .gnt_idx (arbIdx)
            );
        end else begin : gen_sel
            assign arbGnt = '0;
            assign arbIdx = '0;
        end
    endgenerate

    // Pick the candidate channel for this mode, then suppress all readies
    // while held in reset or while a stalled beat occupies the register.
    always_comb begin
        grantVec = '0;
        grantIdx = '0;
        if (MODE == MODE_RR) begin
            grantVec = arbGnt;
            grantIdx = arbIdx;
        end else begin
            grantVec = selOneHot;
            grantIdx = sel;
        end
        if (rst || !loadEn) begin
            grantVec = '0;
        end
    end

    assign in_ready = grantVec;
    assign transfer = |(in_valid & grantVec);

    // One-hot data steering; no arithmetic index, so an unused select value
    // never forms an out-of-range slice.
    always_comb begin
        chData = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grantVec[k]) begin
                chData = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next output state: a load either captures the transferred beat or
    // empties the register; data and channel keep their last values when
    // nothing new arrives so a downstream peek stays stable.
    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outChan_d  = outChan_q;
        if (loadEn) begin
            outValid_d = transfer;
            if (transfer) begin
                outData_d = chData;
                outChan_d = grantIdx;
            end
        end
    end

    // Output register; reset discards any beat immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outChan_q  <= '0;
        end else begin
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outChan_q  <= outChan_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_chan  = outChan_q;

endmodule

// File: tb/tb_mux_n_arb.sv
// -----------------------------------------------------------------------------
// tb_mux_n_arb
// Drives a select-mode and a round-robin-mode instance from the same inputs.
// A behavioural model of each mode is compared every cycle, and directed
// scenarios pin the model with hand-computed values.
// -----------------------------------------------------------------------------
module tb_mux_n_arb;

    localparam int W  = 8;
    localparam int CH = 4;

    logic          clk;
    logic          rst;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0] in_valid;
    logic [1:0]    sel;
    logic          out_ready;

    logic [CH-1:0] inReady0;
    logic [W-1:0]  outData0;
    logic          outValid0;
    logic [1:0]    outChan0;
    logic [CH-1:0] inReady1;
    logic [W-1:0]  outData1;
    logic          outValid1;
    logic [1:0]    outChan1;

    int errors = 0;
    int checks = 0;

    mux_n_arb #(.WIDTH(W), .CHANNELS(CH), .MODE(0)) dutSel (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (inReady0),
        .sel       (sel),
        .out_data  (outData0),
        .out_valid (outValid0),
        .out_ready (out_ready),
        .out_chan  (outChan0)
    );

    mux_n_arb #(.WIDTH(W), .CHANNELS(CH), .MODE(1)) dutRr (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (inReady1),
        .sel       (sel),
        .out_data  (outData1),
        .out_valid (outValid1),
        .out_ready (out_ready),
        .out_chan  (outChan1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare helper shared by the model checker and the directed scenarios.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Next round-robin winner: first valid channel after ptr, wrapping; -1 if none.
    function automatic int rrPick(input int ptr, input logic [CH-1:0] v);
        for (int i = 1; i <= CH; i++) begin
            if (v[(ptr + i) % CH]) return (ptr + i) % CH;
        end
        return -1;
    endfunction

    logic          m0Valid;
    logic [W-1:0]  m0Data;
    int            m0Chan;
    logic          m1Valid;
    logic [W-1:0]  m1Data;
    int            m1Chan;
    int            m1Ptr;
    int            exp1Grant;
    logic          load0;
    logic          load1;
    logic [CH-1:0] exp0Ready;
    logic [CH-1:0] exp1Ready;

    // Expected readies from the model state and the current inputs.
    always_comb begin
        load0     = !m0Valid || out_ready;
        load1     = !m1Valid || out_ready;
        exp1Grant = rrPick(m1Ptr, in_valid);
        exp0Ready = '0;
        exp1Ready = '0;
        if (!rst && load0) exp0Ready[sel] = 1'b1;
        if (!rst && load1 && exp1Grant >= 0) exp1Ready[exp1Grant] = 1'b1;
    end

    // Model state update for both modes.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0Valid <= 1'b0;
            m0Data  <= '0;
            m0Chan  <= 0;
            m1Valid <= 1'b0;
            m1Data  <= '0;
            m1Chan  <= 0;
            m1Ptr   <= CH - 1;
        end else begin
            if (load0) begin
                if (in_valid[sel]) begin
                    m0Valid <= 1'b1;
                    m0Data  <= in_data[int'(sel)*W +: W];
                    m0Chan  <= int'(sel);
                end else begin
                    m0Valid <= 1'b0;
                end
            end
            if (load1) begin
                if (exp1Grant >= 0) begin
                    m1Valid <= 1'b1;
                    m1Data  <= in_data[exp1Grant*W +: W];
                    m1Chan  <= exp1Grant;
                    m1Ptr   <= exp1Grant;
                end else begin
                    m1Valid <= 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("sel.in_ready",  32'(inReady0),  32'(exp0Ready));
        checkOutput("sel.out_valid", 32'(outValid0), 32'(m0Valid));
        checkOutput("sel.out_data",  32'(outData0),  32'(m0Data));
        checkOutput("sel.out_chan",  32'(outChan0),  32'(m0Chan));
        checkOutput("rr.in_ready",   32'(inReady1),  32'(exp1Ready));
        checkOutput("rr.out_valid",  32'(outValid1), 32'(m1Valid));
        checkOutput("rr.out_data",   32'(outData1),  32'(m1Data));
        checkOutput("rr.out_chan",   32'(outChan1),  32'(m1Chan));
    end

    task automatic applyStimulus(input logic [CH-1:0] valid, input logic [1:0] s,
                                 input logic rdy);
        in_valid  = valid;
        sel       = s;
        out_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 32'h40302010;
        applyStimulus(4'b0000, 2'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Reset state, readies held low even with every channel valid.
        in_valid = 4'b1111;
        #1;
        checkOutput("reset sel.in_ready", 32'(inReady0), 32'h0);
        checkOutput("reset rr.in_ready",  32'(inReady1), 32'h0);
        checkOutput("reset out_valid",    32'(outValid0), 32'h0);
        checkOutput("reset out_data",     32'(outData0),  32'h0);
        checkOutput("reset out_chan",     32'(outChan0),  32'h0);
        in_valid = 4'b0000;
        rst      = 1'b0;
        step();

        // Select mode, channel 2.
        in_data = 32'h40A52010;
        applyStimulus(4'b0100, 2'd2, 1'b1);
        #1;
        checkOutput("A sel.in_ready", 32'(inReady0), 32'h4);
        step();
        checkOutput("A out_valid", 32'(outValid0), 32'h1);
        checkOutput("A out_data",  32'(outData0),  32'hA5);
        checkOutput("A out_chan",  32'(outChan0),  32'h2);
        checkOutput("A rr.out_chan", 32'(outChan1), 32'h2);

        // Backpressure: hold 0x11 while sel and data churn.
        in_data = 32'h40A51110;
        applyStimulus(4'b0010, 2'd1, 1'b1);
        step();
        checkOutput("B load data", 32'(outData0), 32'h11);
        checkOutput("B rr chan",   32'(outChan1), 32'h1);
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hDEADBEEF ^ 32'(i * 32'h01010101);
            applyStimulus(4'b1111, (i == 0) ? 2'd0 : ((i == 1) ? 2'd2 : 2'd3), 1'b0);
            #1;
            checkOutput("B stall in_ready", 32'(inReady0), 32'h0);
            step();
            checkOutput("B stall data", 32'(outData0), 32'h11);
            checkOutput("B stall chan", 32'(outChan0), 32'h1);
        end
        in_data = 32'h77302010;
        applyStimulus(4'b1000, 2'd3, 1'b1);
        #1;
        checkOutput("B release in_ready", 32'(inReady0), 32'h8);
        step();
        checkOutput("B reload valid", 32'(outValid0), 32'h1);
        checkOutput("B reload data",  32'(outData0),  32'h77);
        checkOutput("B reload chan",  32'(outChan0),  32'h3);
        checkOutput("B rr reload data", 32'(outData1), 32'h77);

        // Round robin, all channels valid.
        in_data = 32'h40302010;
        applyStimulus(4'b1111, 2'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("C rr chan", 32'(outChan1), 32'(i % 4));
            checkOutput("C rr data", 32'(outData1), 32'(((i % 4) + 1) * 16));
        end

        // Wrap-around with only channels 0 and 3 requesting, ptr at 1.
        step();
        checkOutput("D rr chan ptr1", 32'(outChan1), 32'h1);
        applyStimulus(4'b1001, 2'd3, 1'b1);
        #1;
        checkOutput("D rr in_ready ch3", 32'(inReady1), 32'h8);
        step();
        checkOutput("D rr chan 3", 32'(outChan1), 32'h3);
        checkOutput("D rr data 3", 32'(outData1), 32'h40);
        checkOutput("D rr in_ready ch0", 32'(inReady1), 32'h1);
        step();
        checkOutput("D rr chan 0", 32'(outChan1), 32'h0);
        checkOutput("D rr data 0", 32'(outData1), 32'h10);

        // Idle gap, then a lone request on channel 2.
        applyStimulus(4'b0000, 2'd3, 1'b1);
        step();
        checkOutput("F idle valid 1", 32'(outValid1), 32'h0);
        step();
        checkOutput("F idle valid 2", 32'(outValid1), 32'h0);
        applyStimulus(4'b0100, 2'd3, 1'b1);
        #1;
        checkOutput("F rr in_ready ch2", 32'(inReady1), 32'h4);
        step();
        checkOutput("F rr valid", 32'(outValid1), 32'h1);
        checkOutput("F rr chan",  32'(outChan1),  32'h2);
        checkOutput("F rr data",  32'(outData1),  32'h30);

        // Reset while a beat is stalled.
        applyStimulus(4'b1111, 2'd3, 1'b0);
        step();
        step();
        checkOutput("E stalled valid", 32'(outValid1), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("E async valid", 32'(outValid1), 32'h0);
        checkOutput("E async data",  32'(outData1),  32'h0);
        checkOutput("E async chan",  32'(outChan1),  32'h0);
        checkOutput("E async sel valid", 32'(outValid0), 32'h0);
        step();
        rst = 1'b0;
        applyStimulus(4'b1111, 2'd3, 1'b1);
        #1;
        checkOutput("E rr in_ready ch0", 32'(inReady1), 32'h1);
        step();
        checkOutput("E rr first chan", 32'(outChan1), 32'h0);
        checkOutput("E rr first data", 32'(outData1), 32'h10);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
